// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and state encoding for the instruction cache
package icache_pkg;

   localparam int ICACHE_INDEX_BITS = 8;

   // IDLE serves lookups; MISS waits on the memory controller for one word.
   typedef enum logic {
      ICACHE_IDLE = 1'b0,
      ICACHE_MISS = 1'b1
   } icache_state_e;

   // Word address of a fetch PC: the byte offset inside the word is dropped.
   function automatic logic [31:0] word_addr(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signal bundle of the instruction cache
interface icache_if;

   // fetch unit side
   logic        if_req;
   logic [31:0] if_pc;
   logic        if_hit;
   logic [31:0] if_inst;
   logic        clear;

   // memory controller side
   logic        inst_miss;
   logic [31:0] miss_pc;
   logic        inst_rdy;
   logic [31:0] inst_out;

   // the cache itself
   modport slave (
      input  if_req, if_pc, clear, inst_rdy, inst_out,
      output if_hit, if_inst, inst_miss, miss_pc
   );

   // fetch unit plus memory controller as seen by the cache
   modport master (
      output if_req, if_pc, clear, inst_rdy, inst_out,
      input  if_hit, if_inst, inst_miss, miss_pc
   );

endinterface

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage with async read and one sync write port
module icache_array #(
   parameter int INDEX_BITS = 8,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_idx_i,
   output logic                  rd_valid_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic [31:0]           rd_data_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_idx_i,
   input  logic [TAG_BITS-1:0]   wr_tag_i,
   input  logic [31:0]           wr_data_i
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0] valid_q;
   logic [TAG_BITS-1:0] tag_q [LINES];
   logic [31:0]         data_q [LINES];

   // valid bits are the only reset state; a fill marks its line valid
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // tag and data are plain storage, meaningless until the valid bit is set
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input logic     clk,
   input logic     rst,
   input logic     rdy,
   icache_if.slave bus
);

   icache_state_e state_q, state_d;
   logic [31:0]   miss_pc_q, miss_pc_d;
   logic [31:0]   if_inst_q, if_inst_d;
   logic          if_hit_q, if_hit_d;
   logic          fill_we;

   logic [INDEX_BITS-1:0] rd_idx, wr_idx;
   logic [TAG_BITS-1:0]   req_tag, rd_tag, wr_tag;
   logic                  rd_valid;
   logic [31:0]           rd_data;
   logic                  lookup_hit;
   logic [3:0]            unused_addr_bits;

   // lookups always index by the incoming PC; fills always target the latched miss address
   assign rd_idx  = bus.if_pc[INDEX_BITS+1:2];
   assign req_tag = bus.if_pc[31:INDEX_BITS+2];
   assign wr_idx  = miss_pc_q[INDEX_BITS+1:2];
   assign wr_tag  = miss_pc_q[31:INDEX_BITS+2];
   assign unused_addr_bits = {bus.if_pc[1:0], miss_pc_q[1:0]};

   assign lookup_hit = rd_valid && (rd_tag == req_tag);

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (rd_idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (fill_we),
      .wr_idx_i   (wr_idx),
      .wr_tag_i   (wr_tag),
      .wr_data_i  (bus.inst_out)
   );

   // next state and response: everything holds while rdy is low, except the hit pulse drops
   always_comb begin
      state_d   = state_q;
      miss_pc_d = miss_pc_q;
      if_inst_d = if_inst_q;
      if_hit_d  = 1'b0;
      fill_we   = 1'b0;
      if (rdy && !rst) begin
         unique case (state_q)
            ICACHE_IDLE: begin
               if (bus.if_req && !bus.clear) begin
                  if (lookup_hit) begin
                     if_hit_d  = 1'b1;
                     if_inst_d = rd_data;
                  end else begin
                     miss_pc_d = word_addr(bus.if_pc);
                     state_d   = ICACHE_MISS;
                  end
               end
            end
            ICACHE_MISS: begin
               if (bus.inst_rdy) begin
                  // the returned word is correct even when fetch was flushed, so keep it
                  fill_we = 1'b1;
                  state_d = ICACHE_IDLE;
                  if (!bus.clear) begin
                     if_hit_d  = 1'b1;
                     if_inst_d = bus.inst_out;
                  end
               end else if (bus.clear) begin
                  state_d = ICACHE_IDLE;
               end
            end
            default: state_d = ICACHE_IDLE;
         endcase
      end
   end

   // state and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ICACHE_IDLE;
         miss_pc_q <= '0;
         if_inst_q <= '0;
         if_hit_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         miss_pc_q <= miss_pc_d;
         if_inst_q <= if_inst_d;
         if_hit_q  <= if_hit_d;
      end
   end

   // miss drops combinationally with inst_rdy so the controller never re-reads a stale request
   assign bus.inst_miss = (state_q == ICACHE_MISS) && !bus.inst_rdy;
   assign bus.miss_pc   = miss_pc_q;
   assign bus.if_hit    = if_hit_q;
   assign bus.if_inst   = if_inst_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache with a behavioural memory controller
module tb_icache;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;

   icache_if bus ();

   icache dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int fetches  = 0;
   int aborts   = 0;
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0004: return 32'h0050_0093;
         32'h0000_0404: return 32'h1234_5678;
         32'h0000_0008: return 32'hA000_0008;
         32'h0000_000C: return 32'hC000_000C;
         32'h0000_0010: return 32'h1010_1010;
         default:       return 32'hDEAD_BEEF;
      endcase
   endfunction

   // memory controller: 5 ready cycles after seeing a miss, then holds inst_rdy until consumed
   initial begin
      bit          ab;
      bit          r;
      int          cnt;
      logic [31:0] addr;
      bus.inst_rdy = 1'b0;
      bus.inst_out = '0;
      forever begin
         @(negedge clk);
         if (bus.inst_miss) begin
            fetches++;
            addr = bus.miss_pc;
            cnt  = 0;
            ab   = 1'b0;
            while (cnt < 5 && !ab) begin
               @(negedge clk);
               if (!bus.inst_miss) ab = 1'b1;
               else if (rdy) cnt++;
            end
            if (ab) begin
               aborts++;
            end else begin
               bus.inst_rdy = 1'b1;
               bus.inst_out = mem_word(addr);
               do begin
                  @(posedge clk);
                  r = rdy;
                  @(negedge clk);
               end while (!r);
               bus.inst_rdy = 1'b0;
            end
         end
      end
   end

   // scoreboard monitor: every hit pulse must match the oldest outstanding expectation
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (bus.if_hit) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_hit", 32'(bus.if_hit), 32'd0);
            end else begin
               chk("if_inst", bus.if_inst, exp_q.pop_front());
            end
         end
         if (bus.inst_rdy) chk("miss_low_with_inst_rdy", 32'(bus.inst_miss), 32'd0);
      end
   end

   task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input bit exp_miss,
                        output int lat);
      int f0;
      f0 = fetches;
      exp_q.push_back(exp);
      bus.if_req = 1'b1;
      bus.if_pc  = pc;
      lat = 0;
      @(negedge clk);
      lat = 1;
      if (exp_miss) begin
         chk("miss_raised", 32'(bus.inst_miss), 32'd1);
         chk("miss_pc", bus.miss_pc, pc & 32'hFFFF_FFFC);
      end else begin
         chk("hit_latency_1", 32'(bus.if_hit), 32'd1);
         chk("no_miss_on_hit", 32'(bus.inst_miss), 32'd0);
      end
      while (!bus.if_hit && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.if_hit) chk("fetch_timeout", 32'(lat), 32'd0);
      bus.if_req = 1'b0;
      chk("mem_fetch_count", 32'(fetches - f0), exp_miss ? 32'd1 : 32'd0);
   endtask

   initial begin
      int lat;
      int a0;
      int n;
      bus.if_req = 1'b0;
      bus.if_pc  = '0;
      bus.clear  = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // reset state
      chk("rst_if_hit", 32'(bus.if_hit), 32'd0);
      chk("rst_if_inst", bus.if_inst, 32'd0);
      chk("rst_miss_pc", bus.miss_pc, 32'd0);
      chk("rst_inst_miss", 32'(bus.inst_miss), 32'd0);

      // cold miss then hits
      fetch(32'h4, 32'h0050_0093, 1'b1, lat);
      chk("cold_miss_latency", 32'(lat), 32'd7);
      fetch(32'h4, 32'h0050_0093, 1'b0, lat);
      for (int i = 0; i < 4; i++) fetch(32'h4, 32'h0050_0093, 1'b0, lat);

      // conflict on index 1
      fetch(32'h404, 32'h1234_5678, 1'b1, lat);
      fetch(32'h4, 32'h0050_0093, 1'b1, lat);

      // clear in the second miss cycle
      a0 = aborts;
      bus.if_req = 1'b1;
      bus.if_pc  = 32'h8;
      @(negedge clk);
      chk("miss8_raised", 32'(bus.inst_miss), 32'd1);
      bus.if_req = 1'b0;
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("clear_drops_miss", 32'(bus.inst_miss), 32'd0);
      repeat (3) @(negedge clk);
      chk("model_saw_abort", 32'(aborts - a0), 32'd1);
      fetch(32'h8, 32'hA000_0008, 1'b1, lat);

      // clear in the inst_rdy cycle still fills the line
      bus.if_req = 1'b1;
      bus.if_pc  = 32'hC;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!bus.inst_rdy && n < 50);
      chk("inst_rdy_seen_0xC", 32'(bus.inst_rdy), 32'd1);
      bus.clear  = 1'b1;
      bus.if_req = 1'b0;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("no_hit_on_clear_fill", 32'(bus.if_hit), 32'd0);
      @(negedge clk);
      fetch(32'hC, 32'hC000_000C, 1'b0, lat);

      // rdy stall while inst_rdy is held
      exp_q.push_back(32'h1010_1010);
      bus.if_req = 1'b1;
      bus.if_pc  = 32'h10;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!bus.inst_rdy && n < 50);
      chk("inst_rdy_seen_0x10", 32'(bus.inst_rdy), 32'd1);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_no_hit", 32'(bus.if_hit), 32'd0);
      end
      rdy = 1'b1;
      @(negedge clk);
      chk("hit_after_stall", 32'(bus.if_hit), 32'd1);
      bus.if_req = 1'b0;
      fetch(32'h10, 32'h1010_1010, 1'b0, lat);

      // reset mid-miss invalidates everything
      a0 = aborts;
      bus.if_req = 1'b1;
      bus.if_pc  = 32'h14;
      @(negedge clk);
      chk("miss14_raised", 32'(bus.inst_miss), 32'd1);
      bus.if_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_drops_miss", 32'(bus.inst_miss), 32'd0);
      fetch(32'h4, 32'h0050_0093, 1'b1, lat);
      chk("model_saw_rst_abort", 32'(aborts - a0), 32'd1);
      fetch(32'hC, 32'hC000_000C, 1'b1, lat);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
